ipif_arbiter: RTL and testbench

Two-master arbiter sharing one IPIF register-bank slave, such as a parameter-decode register bank, between the host AXI-IPIF bridge (master 0) and a local configuration master (master 1). It serializes transactions with round-robin fairness, issues each one downstream as a single-cycle chip-enable pulse, routes the slave's ack and read data back to the granted master, and converts a missing slave ack into a timeout ack.

---
 rtl/ipif_arb_pkg.sv | 6 +
 rtl/ipif_arbiter.sv | 132 +++++++++++++
 tb/tb_ipif_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ipif_arb_pkg.sv
// ipif_arb_pkg: shared types and constants for the two-master IPIF arbiter
package ipif_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} arb_state_t;
  typedef enum logic {READ, WRITE} txn_t;
  localparam logic [15:0] TO_SAT = 16'hFFFF;
endpackage

// File: rtl/ipif_arbiter.sv
// ipif_arbiter: round-robin arbiter between two IPIF masters and one register-bank slave
module ipif_arbiter
  import ipif_arb_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int N_REG = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic                          clk,
  input  logic                          IPIF_bus2ip_resetn,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] m0_bus2ip_data,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] m1_bus2ip_data,
  input  logic [N_REG-1:0]              m0_bus2ip_rdce,
  input  logic [N_REG-1:0]              m1_bus2ip_rdce,
  input  logic [N_REG-1:0]              m0_bus2ip_wrce,
  input  logic [N_REG-1:0]              m1_bus2ip_wrce,
  output logic [C_S_AXI_DATA_WIDTH-1:0] m0_ip2bus_data,
  output logic [C_S_AXI_DATA_WIDTH-1:0] m1_ip2bus_data,
  output logic                          m0_ip2bus_rdack,
  output logic                          m1_ip2bus_rdack,
  output logic                          m0_ip2bus_wrack,
  output logic                          m1_ip2bus_wrack,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_bus2ip_data,
  output logic [N_REG-1:0]              s_bus2ip_rdce,
  output logic [N_REG-1:0]              s_bus2ip_wrce,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s_ip2bus_data,
  input  logic                          s_ip2bus_rdack,
  input  logic                          s_ip2bus_wrack,
  output logic                          busy,
  output logic [15:0]                   timeout_count
);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  arb_state_t state_q, state_d;
  txn_t txn_q, txn_d;
  logic last_q, last_d, busy_q, busy_d;
  logic [15:0] timer_q, timer_d, tcnt_q, tcnt_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] s_data_q, s_data_d;
  logic [N_REG-1:0] s_rdce_q, s_rdce_d, s_wrce_q, s_wrce_d;
  logic [1:0] rdack_q, rdack_d, wrack_q, wrack_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] mdata_q [2];
  logic [C_S_AXI_DATA_WIDTH-1:0] mdata_d [2];
  logic req0, req1, gnt, hit;
  logic [N_REG-1:0] sel_wr, sel_rd;
  assign req0   = |m0_bus2ip_rdce | |m0_bus2ip_wrce;
  assign req1   = |m1_bus2ip_rdce | |m1_bus2ip_wrce;
  assign gnt    = (req0 & req1) ? ~last_q : req1;
  assign sel_wr = gnt ? m1_bus2ip_wrce : m0_bus2ip_wrce;
  assign sel_rd = gnt ? m1_bus2ip_rdce : m0_bus2ip_rdce;
  assign hit    = txn_q == READ ? s_ip2bus_rdack : s_ip2bus_wrack;
  always_comb begin
    state_d  = state_q;
    txn_d    = txn_q;
    last_d   = last_q;
    timer_d  = timer_q;
    tcnt_d   = tcnt_q;
    s_data_d = s_data_q;
    s_rdce_d = s_rdce_q;
    s_wrce_d = s_wrce_q;
    rdack_d  = '0;
    wrack_d  = '0;
    mdata_d  = mdata_q;
    unique case (state_q)
      IDLE: if (req0 | req1) begin
        last_d   = gnt;
        txn_d    = |sel_wr ? WRITE : READ;
        s_wrce_d = sel_wr;
        s_rdce_d = |sel_wr ? '0 : sel_rd;
        s_data_d = gnt ? m1_bus2ip_data : m0_bus2ip_data;
        timer_d  = '0;
        state_d  = ISSUE;
      end
      ISSUE: begin
        s_data_d = '0;
        s_rdce_d = '0;
        s_wrce_d = '0;
        state_d  = WAIT;
      end
      WAIT: if (hit || timer_q == TMO_LAST) begin
        rdack_d[last_q] = txn_q == READ;
        wrack_d[last_q] = txn_q == WRITE;
        if (txn_q == READ) mdata_d[last_q] = hit ? s_ip2bus_data : TIMEOUT_DATA;
        if (!hit) tcnt_d = tcnt_q == TO_SAT ? tcnt_q : tcnt_q + 16'd1;
        state_d = RELEASE;
      end else begin
        timer_d = timer_q + 16'd1;
      end
      RELEASE: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge IPIF_bus2ip_resetn) begin
    if (!IPIF_bus2ip_resetn) begin
      state_q  <= IDLE;
      txn_q    <= READ;
      last_q   <= 1'b1;
      busy_q   <= 1'b0;
      timer_q  <= '0;
      tcnt_q   <= '0;
      s_data_q <= '0;
      s_rdce_q <= '0;
      s_wrce_q <= '0;
      rdack_q  <= '0;
      wrack_q  <= '0;
      mdata_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      txn_q    <= txn_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      timer_q  <= timer_d;
      tcnt_q   <= tcnt_d;
      s_data_q <= s_data_d;
      s_rdce_q <= s_rdce_d;
      s_wrce_q <= s_wrce_d;
      rdack_q  <= rdack_d;
      wrack_q  <= wrack_d;
      mdata_q  <= mdata_d;
    end
  end
  assign m0_ip2bus_data  = mdata_q[0];
  assign m1_ip2bus_data  = mdata_q[1];
  assign m0_ip2bus_rdack = rdack_q[0];
  assign m1_ip2bus_rdack = rdack_q[1];
  assign m0_ip2bus_wrack = wrack_q[0];
  assign m1_ip2bus_wrack = wrack_q[1];
  assign s_bus2ip_data   = s_data_q;
  assign s_bus2ip_rdce   = s_rdce_q;
  assign s_bus2ip_wrce   = s_wrce_q;
  assign busy            = busy_q;
  assign timeout_count   = tcnt_q;
endmodule

// File: tb/tb_ipif_arbiter.sv
// tb_ipif_arbiter: scoreboard bench for ipif_arbiter with a behavioural register-bank slave
module tb_ipif_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn = 1'b1;
  logic [31:0] m0_wdata = '0, m1_wdata = '0, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [1:0] m0_rdce = '0, m0_wrce = '0, m1_rdce = '0, m1_wrce = '0, s_rdce, s_wrce;
  logic m0_rdack, m0_wrack, m1_rdack, m1_wrack, s_rdack, s_wrack, busy;
  logic [15:0] tcount;
  int n_tests = 0, n_fail = 0;
  typedef struct {logic [1:0] rd; logic [1:0] wr; logic [31:0] d;} iss_t;
  typedef struct {int m; logic rd; logic [31:0] d;} ack_t;
  iss_t iss_q[$];
  ack_t ack_q[$];
  int slave_mode = 0;
  int ack_left = 0;
  logic ack_rd = 1'b0, manual_rdack = 1'b0, ce_prev = 1'b0;
  logic [31:0] slave_rdata = '0;

  ipif_arbiter dut (
    .clk(clk), .IPIF_bus2ip_resetn(rstn),
    .m0_bus2ip_data(m0_wdata), .m1_bus2ip_data(m1_wdata),
    .m0_bus2ip_rdce(m0_rdce), .m1_bus2ip_rdce(m1_rdce),
    .m0_bus2ip_wrce(m0_wrce), .m1_bus2ip_wrce(m1_wrce),
    .m0_ip2bus_data(m0_rdata), .m1_ip2bus_data(m1_rdata),
    .m0_ip2bus_rdack(m0_rdack), .m1_ip2bus_rdack(m1_rdack),
    .m0_ip2bus_wrack(m0_wrack), .m1_ip2bus_wrack(m1_wrack),
    .s_bus2ip_data(s_wdata), .s_bus2ip_rdce(s_rdce), .s_bus2ip_wrce(s_wrce),
    .s_ip2bus_data(s_rdata), .s_ip2bus_rdack(s_rdack), .s_ip2bus_wrack(s_wrack),
    .busy(busy), .timeout_count(tcount)
  );

  // mode 0: one-cycle registered ack, 1: silent, 2: ack held for two cycles
  always @(posedge clk) begin
    if ((|s_rdce || |s_wrce) && slave_mode != 1) begin
      ack_left <= slave_mode == 2 ? 2 : 1;
      ack_rd   <= |s_rdce;
    end else if (ack_left > 0) ack_left <= ack_left - 1;
  end
  assign s_rdack = (ack_left > 0 && ack_rd) || manual_rdack;
  assign s_wrack = ack_left > 0 && !ack_rd;
  assign s_rdata = slave_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    iss_t ie;
    ack_t ae;
    logic ce_now, m1_any;
    ce_now = |s_rdce || |s_wrce;
    if (ce_now) begin
      check("ce_width", 32'(ce_prev), 32'd0);
      if (iss_q.size() == 0) check("unexp_issue", 32'(iss_q.size()), 32'd1);
      else begin
        ie = iss_q.pop_front();
        check("iss_rdce", 32'(s_rdce), 32'(ie.rd));
        check("iss_wrce", 32'(s_wrce), 32'(ie.wr));
        check("iss_data", s_wdata, ie.d);
      end
    end
    ce_prev = ce_now;
    m1_any = m1_rdack | m1_wrack;
    if (m0_rdack | m0_wrack | m1_any) begin
      if (ack_q.size() == 0) check("unexp_ack", 32'(ack_q.size()), 32'd1);
      else begin
        ae = ack_q.pop_front();
        check("ack_master", 32'(m1_any), 32'(ae.m));
        check("ack_is_rd", 32'(m0_rdack | m1_rdack), 32'(ae.rd));
        if (ae.rd) check("ack_rdata", m1_any ? m1_rdata : m0_rdata, ae.d);
      end
    end
  end

  task automatic expect_txn(input int m, input logic [1:0] rd, input logic [1:0] wr,
                            input logic [31:0] wd, input logic [31:0] rdata);
    iss_q.push_back('{rd: (wr != 0) ? 2'b00 : rd, wr: wr, d: wd});
    ack_q.push_back('{m: m, rd: wr == 0, d: rdata});
  endtask

  task automatic txn(input int m, input logic [1:0] rd, input logic [1:0] wr,
                     input logic [31:0] wd, input int exp_lat);
    int n;
    @(posedge clk); #1;
    if (m == 0) begin m0_rdce = rd; m0_wrce = wr; m0_wdata = wd; end
    else begin m1_rdce = rd; m1_wrce = wr; m1_wdata = wd; end
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n == 1) check("busy", 32'(busy), 32'd1);
      if (m == 0 ? (m0_rdack | m0_wrack) : (m1_rdack | m1_wrack)) break;
    end
    if (exp_lat > 0) check("latency", 32'(n), 32'(exp_lat));
    else check("ack_seen", 32'(n < 60), 32'd1);
    @(posedge clk); #1;
    if (m == 0) begin m0_rdce = '0; m0_wrce = '0; end
    else begin m1_rdce = '0; m1_wrce = '0; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tcount", 32'(tcount), 32'd0);
    check("rst_s_ce", 32'({s_rdce, s_wrce}), 32'd0);
    check("rst_acks", 32'({m0_rdack, m0_wrack, m1_rdack, m1_wrack}), 32'd0);
    check("rst_rdata", m0_rdata | m1_rdata | s_wdata, 32'd0);
    rstn = 1'b1;
    // simultaneous first requests: m0 wins, m1 follows four cycles later
    expect_txn(0, 2'b00, 2'b01, 32'h1111, 'x);
    expect_txn(1, 2'b00, 2'b10, 32'h2222, 'x);
    fork
      txn(0, 2'b00, 2'b01, 32'h1111, 3);
      txn(1, 2'b00, 2'b10, 32'h2222, 7);
    join
    expect_txn(0, 2'b00, 2'b01, 32'h1234, 'x);
    txn(0, 2'b00, 2'b01, 32'h1234, 3);
    slave_rdata = 32'hA5A5_0001;
    expect_txn(1, 2'b10, 2'b00, 32'h0, 32'hA5A5_0001);
    txn(1, 2'b10, 2'b00, 32'h0, 3);
    check("m0_untouched", m0_rdata, 32'h0);
    check("m1_rd_hold", m1_rdata, 32'hA5A5_0001);
    // both masters re-request as soon as they are served
    expect_txn(0, 2'b00, 2'b01, 32'hA0, 'x);
    expect_txn(1, 2'b00, 2'b10, 32'hB0, 'x);
    expect_txn(0, 2'b00, 2'b01, 32'hA1, 'x);
    expect_txn(1, 2'b00, 2'b10, 32'hB1, 'x);
    fork
      begin txn(0, 2'b00, 2'b01, 32'hA0, 0); txn(0, 2'b00, 2'b01, 32'hA1, 0); end
      begin txn(1, 2'b00, 2'b10, 32'hB0, 0); txn(1, 2'b00, 2'b10, 32'hB1, 0); end
    join
    expect_txn(1, 2'b10, 2'b01, 32'hCAFE, 'x);
    txn(1, 2'b10, 2'b01, 32'hCAFE, 3);
    expect_txn(0, 2'b00, 2'b11, 32'hBEEF, 'x);
    txn(0, 2'b00, 2'b11, 32'hBEEF, 3);
    slave_mode = 1;
    expect_txn(0, 2'b01, 2'b00, 32'h0, 32'hDEAD_BEEF);
    txn(0, 2'b01, 2'b00, 32'h0, 18);
    check("tcount_1", 32'(tcount), 32'd1);
    manual_rdack = 1'b1;
    @(posedge clk); #1;
    manual_rdack = 1'b0;
    repeat (3) @(negedge clk);
    slave_mode = 2;
    slave_rdata = 32'h5555_0002;
    expect_txn(1, 2'b10, 2'b00, 32'h0, 32'h5555_0002);
    txn(1, 2'b10, 2'b00, 32'h0, 3);
    check("m0_hold_tmo", m0_rdata, 32'hDEAD_BEEF);
    slave_mode = 0;
    slave_rdata = 32'h0BAD_F00D;
    expect_txn(0, 2'b01, 2'b00, 32'h0, 32'h0BAD_F00D);
    txn(0, 2'b01, 2'b00, 32'h0, 3);
    // reset while the slave stays silent and the arbiter sits in WAIT
    slave_mode = 1;
    iss_q.push_back('{rd: 2'b00, wr: 2'b01, d: 32'h77});
    @(posedge clk); #1;
    m0_wrce = 2'b01; m0_wdata = 32'h77;
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_tcount", 32'(tcount), 32'd0);
    check("mr_rdata", m0_rdata, 32'd0);
    check("mr_acks", 32'({m0_rdack, m0_wrack, m1_rdack, m1_wrack}), 32'd0);
    m0_wrce = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    slave_mode = 0;
    slave_rdata = 32'h1357_9BDF;
    expect_txn(1, 2'b01, 2'b00, 32'h0, 32'h1357_9BDF);
    txn(1, 2'b01, 2'b00, 32'h0, 3);
    repeat (3) @(negedge clk);
    check("iss_q_empty", 32'(iss_q.size()), 32'd0);
    check("ack_q_empty", 32'(ack_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
